updown_counter_n: RTL and testbench
===================================

# updown_counter_n

Parametrised synchronous up/down counter with a Moore terminal-count output `l` (the G block), parallel load, count enable and a wrap-event pulse. It generalises the 2-bit `x`-directed counter to WIDTH bits with a programmable top value. It serves as the standard counting primitive for lab designs and downstream sequence detectors.

## Interface
- `WIDTH`, 4: counter width in bits, ≥1.
- `MAX_VAL`, 2**WIDTH-1: top of count range; count spans 0..MAX_VAL; must be ≤ 2**WIDTH-1.
- `RESET_VAL`, 0: value of `q` after reset; must be ≤ MAX_VAL.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  count enable.
- `x`  in  1  direction: 1 = up, 0 = down.
- `load`  in  1  parallel load strobe.
- `d`  in  WIDTH  load value.
- `q`  out  WIDTH  registered count.
- `l`  out  1  terminal count (G block output), Moore.
- `dir`  out  1  registered direction of last enabled step.
- `wrap`  out  1  one-cycle pulse, counter wrapped on previous edge.

## Operation
- Priority per edge: reset > load > en > hold.
- Reset: `q`=RESET_VAL, `dir`=1, `wrap`=0; `l` follows decode (1 only if RESET_VAL==MAX_VAL).
- Load: `q` ← min(`d`, MAX_VAL); `dir` and the other state unchanged; `wrap`=0.
- En, `x`=1: `q`==MAX_VAL → `q`=0, `wrap`=1; else `q`+1, `wrap`=0. `dir` ← 1.
- En, `x`=0: `q`==0 → `q`=MAX_VAL, `wrap`=1; else `q`-1, `wrap`=0. `dir` ← 0.
- No en, no load: `q`, `dir` hold; `wrap`=0.
- `x` is ignored when `en`=0; direction changes take effect on the first enabled edge.
- `l` = (`dir`=1 AND `q`==MAX_VAL) OR (`dir`=0 AND `q`==0); a pure function of registered state, with no path from inputs.
- Arithmetic: modulo MAX_VAL+1, never 2**WIDTH unless MAX_VAL=2**WIDTH-1; `q` never exceeds MAX_VAL.

## Timing
- Latency: 1 clock from input sample to `q`/`dir`/`wrap` change.
- `l` is valid in the same cycle as the `q`/`dir` it decodes (combinational off flops, glitch-free w.r.t. inputs).
- `wrap` is high for exactly one cycle per wrap; back-to-back wraps (MAX_VAL=0) keep it high each enabled cycle.
- Reset asserted mid-count: next edge forces reset values regardless of `load`/`en`.
- `load` and `en` together: load wins, no step, `wrap`=0.

## Configuration
- `UDC_SATURATE_EN` defined: at the range limit in the current direction, `q` holds instead of wrapping; `wrap` stays 0; `l` stays 1 while held.
- Undefined: modulo wrap behaviour as above.

## Structure
- Package `udc_pkg`: `DIR_UP`=1'b1, `DIR_DOWN`=1'b0 constants and the direction type.
- Sub-module `ud_gblock`: parameter WIDTH/MAX_VAL; inputs `q`, `dir`; output `l`. Top instantiates it once.

## Test plan
- WIDTH=3, MAX_VAL=5: reset 2 cycles, then `en`=1, `x`=1 for 7 edges -> `q` 0,1,2,3,4,5,0,1; `l`=1 only while `q`=5; `wrap` pulses once after 5→0.
- Same config, `x`=0 from `q`=2 -> `q` 1,0,5,4; `l`=1 at `q`=0 with `dir`=0; `wrap` pulses after 0→5.
- `load`=1, `d`=7, `en`=1 -> `q`=5 (clipped), no step, `wrap`=0; `d`=3 -> `q`=3.
- Direction flip at `q`=5 (`dir`=1, `l`=1), `en`=0, `x`=0 -> `l` stays 1; next enabled edge -> `q`=4, `dir`=0, `l`=0.
- `reset`=1 with `en`=1, `load`=1 mid-count at `q`=3 -> `q`=RESET_VAL, `dir`=1, `wrap`=0 after one edge.
- `UDC_SATURATE_EN` defined, up count past 5 -> `q` holds 5, `l`=1, `wrap` never asserts; down from 0 holds 0.

Source files
------------

// File: rtl/updown_counter_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udc_pkg
//  Description : Shared types and constants for updown_counter_n.
//                Direction encoding is the same in every file: 1 = up and
//                0 = down.
//  Revision    : 1.0  initial release
// ============================================================================
package udc_pkg;

  // Direction of the last enabled step. The enum members are the named
  // constants DIR_UP and DIR_DOWN.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : udc_pkg
`default_nettype wire

// File: rtl/updown_counter_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_n_if
//  Description : Control and status bundle for updown_counter_n.
//                The master drives en / x / load / d.
//                The slave (the counter) drives q / l / dir / wrap.
//  Ports       : none. Parameter WIDTH sets the width of d and q.
//  Revision    : 1.0  initial release
// ============================================================================
interface updown_counter_n_if #(
  parameter int WIDTH = 4
);

  logic             en;    // count enable
  logic             x;     // direction request: 1 = up, 0 = down
  logic             load;  // parallel load strobe
  logic [WIDTH-1:0] d;     // load value
  logic [WIDTH-1:0] q;     // registered count
  logic             l;     // terminal count, Moore
  logic             dir;   // registered direction of last enabled step
  logic             wrap;  // one-cycle wrap pulse

  modport master (
    output en, x, load, d,
    input  q, l, dir, wrap
  );

  modport slave (
    input  en, x, load, d,
    output q, l, dir, wrap
  );

endinterface : updown_counter_n_if
`default_nettype wire

// File: rtl/updown_counter_n_gblock.sv
`default_nettype none
// ============================================================================
//  Module      : ud_gblock
//  Description : Terminal-count decode (G block).
//                l is 1 when the count sits at the limit of its current
//                direction. It decodes registered state only, so it has no
//                path from any input.
//  Ports       : q   [WIDTH-1:0] in   registered count
//                dir              in   registered direction
//                l                out  terminal count
//  Revision    : 1.0  initial release
// ============================================================================
module ud_gblock
  import udc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  wire logic [WIDTH-1:0] q,
  input  wire dir_e             dir,
  output      logic             l
);

  localparam logic [WIDTH-1:0] C_MAX_VAL = WIDTH'(MAX_VAL);

  assign l = ((dir == DIR_UP)   && (q == C_MAX_VAL)) ||
             ((dir == DIR_DOWN) && (q == '0));

endmodule : ud_gblock
`default_nettype wire

// File: rtl/updown_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_n
//  Description : WIDTH-bit synchronous up/down counter.
//                - Counts modulo MAX_VAL+1.
//                - Parallel load of d, clipped to MAX_VAL.
//                - Count enable and a one-cycle wrap pulse.
//                - Moore terminal-count output l.
//                Priority on each edge: reset > load > en > hold.
//                Optional build macro UDC_SATURATE_EN: at the range limit of
//                the current direction the count holds instead of wrapping,
//                and wrap stays 0.
//  Ports       : clk    in   clock, rising edge
//                reset  in   synchronous, active-high
//                bus    slave modport of updown_counter_n_if
//                       (en, x, load, d in; q, l, dir, wrap out)
//  Revision    : 1.0  initial release
// ============================================================================
module updown_counter_n
  import udc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int RESET_VAL = 0
) (
  input wire logic          clk,
  input wire logic          reset,
  updown_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] C_MAX_VAL   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_RESET_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  dir_e             dir_q,   dir_d;
  logic             wrap_q,  wrap_d;

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      // Values above the top of range are clipped, never wrapped.
      count_d = (bus.d > C_MAX_VAL) ? C_MAX_VAL : bus.d;
    end else if (bus.en) begin
      if (bus.x) begin
        dir_d = DIR_UP;
        if (count_q == C_MAX_VAL) begin
`ifdef UDC_SATURATE_EN
          count_d = count_q;
`else
          count_d = '0;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        dir_d = DIR_DOWN;
        if (count_q == '0) begin
`ifdef UDC_SATURATE_EN
          count_d = count_q;
`else
          count_d = C_MAX_VAL;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= C_RESET_VAL;
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  ud_gblock #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_gblock (
    .q   (count_q),
    .dir (dir_q),
    .l   (bus.l)
  );

  assign bus.q    = count_q;
  assign bus.dir  = dir_q;
  assign bus.wrap = wrap_q;

endmodule : updown_counter_n
`default_nettype wire

// File: tb/tb_updown_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_counter_n
//  Description : Self-checking bench for updown_counter_n.
//                Configuration: WIDTH=3, MAX_VAL=5, RESET_VAL=0.
//                Directed vectors carry hand-computed expectations. These go
//                into a queue; a monitor compares them one edge later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_updown_counter_n;

`ifdef UDC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int       id;
    logic [2:0] eq;
    logic       edir;
    logic       ewrap;
    logic       el;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  updown_counter_n_if #(.WIDTH(3)) bus ();

  updown_counter_n #(
    .WIDTH     (3),
    .MAX_VAL   (5),
    .RESET_VAL (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   vec_id  = 0;

  // Drive one vector on the falling edge. After the rising edge, queue
  // the state the counter must then hold.
  task automatic step(input logic rst, input logic ld, input logic en,
                      input logic x, input logic [2:0] d,
                      input logic [2:0] eq, input logic edir,
                      input logic ewrap, input logic el);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    bus.load = ld;
    bus.en   = en;
    bus.x    = x;
    bus.d    = d;
    @(posedge clk);
    e.id = vec_id; e.eq = eq; e.edir = edir; e.ewrap = ewrap; e.el = el;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: the counter presents its state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (bus.q === e.eq) n_pass++;
        else $display("FAIL q vec%0d: got %0d expected %0d", e.id, bus.q, e.eq);
        n_total++;
        if (bus.dir === e.edir) n_pass++;
        else $display("FAIL dir vec%0d: got %b expected %b", e.id, bus.dir, e.edir);
        n_total++;
        if (bus.wrap === e.ewrap) n_pass++;
        else $display("FAIL wrap vec%0d: got %b expected %b", e.id, bus.wrap, e.ewrap);
        n_total++;
        if (bus.l === e.el) n_pass++;
        else $display("FAIL l vec%0d: got %b expected %b", e.id, bus.l, e.el);
      end
    end
  end

  initial begin
    int guard;
    bus.en = 1'b0; bus.x = 1'b0; bus.load = 1'b0; bus.d = 3'd0;

    //    rst ld en x  d      q                 dir   wrap        l
    // Reset for 2 cycles.
    step(1, 0, 0, 0, 3'd0,  3'd0,             1'b1, 1'b0,       1'b0);
    step(1, 0, 0, 0, 3'd0,  3'd0,             1'b1, 1'b0,       1'b0);
    // Count up 7 edges: 1,2,3,4,5 then wrap to 0, then 1.
    step(0, 0, 1, 1, 3'd0,  3'd1,             1'b1, 1'b0,       1'b0);
    step(0, 0, 1, 1, 3'd0,  3'd2,             1'b1, 1'b0,       1'b0);
    step(0, 0, 1, 1, 3'd0,  3'd3,             1'b1, 1'b0,       1'b0);
    step(0, 0, 1, 1, 3'd0,  3'd4,             1'b1, 1'b0,       1'b0);
    step(0, 0, 1, 1, 3'd0,  3'd5,             1'b1, 1'b0,       1'b1);
    step(0, 0, 1, 1, 3'd0,  SAT ? 3'd5 : 3'd0, 1'b1, 1'b0 & ~SAT | (~SAT), SAT);
    step(0, 0, 1, 1, 3'd0,  SAT ? 3'd5 : 3'd1, 1'b1, 1'b0,       SAT);
    // Load 2 with en=0, then count down: 1, 0, then wrap to 5, then 4.
    step(0, 1, 0, 0, 3'd2,  3'd2,             1'b1, 1'b0,       1'b0);
    step(0, 0, 1, 0, 3'd0,  3'd1,             1'b0, 1'b0,       1'b0);
    step(0, 0, 1, 0, 3'd0,  3'd0,             1'b0, 1'b0,       1'b1);
    step(0, 0, 1, 0, 3'd0,  SAT ? 3'd0 : 3'd5, 1'b0, ~SAT,       SAT);
    step(0, 0, 1, 0, 3'd0,  SAT ? 3'd0 : 3'd4, 1'b0, 1'b0,       SAT);
    // Load wins over en; d=7 clips to 5, dir stays 0.
    step(0, 1, 1, 1, 3'd7,  3'd5,             1'b0, 1'b0,       1'b0);
    step(0, 1, 0, 0, 3'd3,  3'd3,             1'b0, 1'b0,       1'b0);
    // Up to 5, then idle with x=0: l stays 1. Then an enabled down step.
    step(0, 0, 1, 1, 3'd0,  3'd4,             1'b1, 1'b0,       1'b0);
    step(0, 0, 1, 1, 3'd0,  3'd5,             1'b1, 1'b0,       1'b1);
    step(0, 0, 0, 0, 3'd0,  3'd5,             1'b1, 1'b0,       1'b1);
    step(0, 0, 1, 0, 3'd0,  3'd4,             1'b0, 1'b0,       1'b0);
    // Reset mid-count at 3, with load and en also asserted.
    step(0, 1, 0, 0, 3'd3,  3'd3,             1'b0, 1'b0,       1'b0);
    step(1, 1, 1, 0, 3'd6,  3'd0,             1'b1, 1'b0,       1'b0);
    // Hold; x is ignored while en=0.
    step(0, 0, 0, 1, 3'd0,  3'd0,             1'b1, 1'b0,       1'b0);
    // Down from 0 while dir=1: wrap to 5, or hold at 0 when saturating.
    step(0, 0, 1, 0, 3'd0,  SAT ? 3'd0 : 3'd5, 1'b0, ~SAT,       SAT);
    // Load 5 (dir stays 0, so l=0). Then up at the top, then idle.
    step(0, 1, 0, 0, 3'd5,  3'd5,             1'b0, 1'b0,       1'b0);
    step(0, 0, 1, 1, 3'd0,  SAT ? 3'd5 : 3'd0, 1'b1, ~SAT,       SAT);
    step(0, 0, 0, 0, 3'd0,  SAT ? 3'd5 : 3'd0, 1'b1, 1'b0,       SAT);

    // Let the monitor drain the queue, with a cycle bound.
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_updown_counter_n
`default_nettype wire
